// File: rtl/line_burst_if.sv
// line_burst_if: bundles the L2-side line request port and the memory-side
// beat-burst port of line_burst_adaptor. The adaptor connects through the
// slave modport; the requester/memory side (arbiter plus memory, or a bench)
// uses the master modport.
interface line_burst_if #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
);
  // L2 side: one line per request
  logic              read_L2;
  logic              write_L2;
  logic [31:0]       addr_L2;
  logic [LINE_W-1:0] wdata_L2;
  logic [LINE_W-1:0] rdata_L2;
  logic              resp_L2;
  // Memory side: NB beats per burst
  logic              pmem_read;
  logic              pmem_write;
  logic [31:0]       pmem_address;
  logic [BEAT_W-1:0] pmem_wdata;
  logic [BEAT_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  read_L2, write_L2, addr_L2, wdata_L2, pmem_rdata, pmem_resp,
    output rdata_L2, resp_L2, pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output read_L2, write_L2, addr_L2, wdata_L2, pmem_rdata, pmem_resp,
    input  rdata_L2, resp_L2, pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/line_burst_adaptor.sv
// line_burst_adaptor: converts one LINE_W-bit cache-line read or write into a
// burst of NB = LINE_W/BEAT_W memory beats, one beat per pmem_resp.
// Optional feature: define LINE_ADDR_ALIGN_EN to clear the byte-offset bits
// of the burst address so it always points at the start of the line.
module line_burst_adaptor #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input logic         clk,
  input logic         rst,
  line_burst_if.slave bus
);

  localparam int NB    = LINE_W / BEAT_W;
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam logic [31:0] OFF_MASK = 32'((64'd1 << OFF_W) - 64'd1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [LINE_W-1:0] line_q, line_d;    // write line, or read line being assembled
  logic [LINE_W-1:0] rdata_q, rdata_d;  // last completed read line
  logic              last_beat;
  logic [31:0]       burst_addr;

  assign last_beat = bus.pmem_resp && (cnt_q == CNT_W'(NB - 1));

`ifdef LINE_ADDR_ALIGN_EN
  assign burst_addr = addr_q & ~OFF_MASK;
`else
  assign burst_addr = addr_q;
`endif

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: read wins over write; bursts end on the last beat only
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.read_L2)       state_d = READ;
        else if (bus.write_L2) state_d = WRITE;
      end
      READ, WRITE: if (last_beat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: request capture, beat assembly, beat counter
  always_comb begin
    addr_d  = addr_q;
    line_d  = line_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.read_L2) begin
          addr_d = bus.addr_L2;
        end else if (bus.write_L2) begin
          addr_d = bus.addr_L2;
          line_d = bus.wdata_L2;
        end
      end
      READ: begin
        if (bus.pmem_resp) begin
          line_d[int'(cnt_q)*BEAT_W +: BEAT_W] = bus.pmem_rdata;
          cnt_d = last_beat ? '0 : cnt_q + CNT_W'(1);
          if (last_beat) rdata_d = line_d;
        end
      end
      WRITE: begin
        if (bus.pmem_resp) cnt_d = last_beat ? '0 : cnt_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  // Datapath registers
  // NOTE: the line buffers are plain registers, not a RAM, and reset clears
  // them so no previous line's data is visible after a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      line_q  <= '0;
      rdata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs decoded from state; memory-side outputs are zero outside bursts
  always_comb begin
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = '0;
    bus.pmem_wdata   = '0;
    bus.resp_L2      = 1'b0;
    unique case (state_q)
      READ: begin
        bus.pmem_read    = 1'b1;
        bus.pmem_address = burst_addr;
      end
      WRITE: begin
        bus.pmem_write   = 1'b1;
        bus.pmem_address = burst_addr;
        bus.pmem_wdata   = line_q[int'(cnt_q)*BEAT_W +: BEAT_W];
      end
      DONE:    bus.resp_L2 = 1'b1;
      default: ;
    endcase
  end

  assign bus.rdata_L2 = rdata_q;

endmodule

// File: tb/tb_line_burst_adaptor.sv
// tb_line_burst_adaptor: directed and randomized line reads/writes against a
// reference built from the line/beat rules (line = concatenation of beats,
// beat i = bits [i*BEAT_W +: BEAT_W] of the line).
module tb_line_burst_adaptor;
  localparam int LINE_W = 256;
  localparam int BEAT_W = 64;
  localparam int NB     = LINE_W / BEAT_W;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  logic [BEAT_W-1:0] beats [NB];
  logic [LINE_W-1:0] exp_rdata;

  line_burst_if #(.LINE_W(LINE_W), .BEAT_W(BEAT_W)) bus ();

  line_burst_adaptor #(.LINE_W(LINE_W), .BEAT_W(BEAT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [LINE_W-1:0] obs,
                       input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [BEAT_W-1:0] rand_beat();
    logic [BEAT_W-1:0] r;
    for (int k = 0; k < BEAT_W; k += 32) r[k +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] r;
    for (int k = 0; k < LINE_W; k += 32) r[k +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [31:0] exp_addr(input logic [31:0] a);
`ifdef LINE_ADDR_ALIGN_EN
    return a - (a % (LINE_W / 8));
`else
    return a;
`endif
  endfunction

  // One read burst. fresh: draw random beats, else use beats[] as set.
  // gap<0: random 0..2 idle cycles before each beat. both: also raise write_L2.
  // poke: raise write_L2 and pmem_resp during DONE. stop_after>=0: return
  // while still mid-burst after that many beats.
  task automatic do_read(input logic [31:0] addr, input bit fresh, input int gap,
                         input bit both, input bit poke, input int stop_after);
    logic [LINE_W-1:0] line;
    int g;
    line = '0;
    for (int i = 0; i < NB; i++) begin
      if (fresh) beats[i] = rand_beat();
      line = line | (LINE_W'(beats[i]) << (i * BEAT_W));
    end
    bus.read_L2  = 1'b1;
    bus.write_L2 = both;
    bus.addr_L2  = addr;
    bus.wdata_L2 = rand_line();
    @(negedge clk);
    bus.read_L2  = 1'b0;
    bus.write_L2 = 1'b0;
    bus.addr_L2  = $urandom();
    for (int i = 0; i < NB; i++) begin
      if (stop_after == i) return;
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      for (int k = 0; k <= g; k++) begin
        bus.pmem_resp  = (k == g);
        bus.pmem_rdata = (k == g) ? beats[i] : rand_beat();
        check("rd_pmem_read", bus.pmem_read, 1'b1);
        check("rd_pmem_write", bus.pmem_write, 1'b0);
        check("rd_address", bus.pmem_address, exp_addr(addr));
        check("rd_resp_early", bus.resp_L2, 1'b0);
        @(negedge clk);
      end
    end
    bus.pmem_resp  = poke;
    bus.write_L2   = poke;
    bus.pmem_rdata = rand_beat();
    check("rd_done_resp", bus.resp_L2, 1'b1);
    check("rd_done_pmem_read", bus.pmem_read, 1'b0);
    check("rd_done_pmem_write", bus.pmem_write, 1'b0);
    check("rd_rdata", bus.rdata_L2, line);
    exp_rdata = line;
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    bus.write_L2  = 1'b0;
    check("rd_after_resp", bus.resp_L2, 1'b0);
    check("rd_after_pmem_read", bus.pmem_read, 1'b0);
    check("rd_after_pmem_write", bus.pmem_write, 1'b0);
    check("rd_after_rdata", bus.rdata_L2, exp_rdata);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [LINE_W-1:0] line,
                          input int gap);
    logic [BEAT_W-1:0] exp_beat;
    int g;
    bus.write_L2 = 1'b1;
    bus.addr_L2  = addr;
    bus.wdata_L2 = line;
    @(negedge clk);
    bus.write_L2 = 1'b0;
    bus.addr_L2  = $urandom();
    bus.wdata_L2 = rand_line();
    for (int i = 0; i < NB; i++) begin
      exp_beat = BEAT_W'(line >> (i * BEAT_W));
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      for (int k = 0; k <= g; k++) begin
        bus.pmem_resp  = (k == g);
        bus.pmem_rdata = rand_beat();
        check("wr_pmem_write", bus.pmem_write, 1'b1);
        check("wr_pmem_read", bus.pmem_read, 1'b0);
        check("wr_address", bus.pmem_address, exp_addr(addr));
        check("wr_wdata", bus.pmem_wdata, exp_beat);
        check("wr_resp_early", bus.resp_L2, 1'b0);
        @(negedge clk);
      end
    end
    bus.pmem_resp = 1'b0;
    check("wr_done_resp", bus.resp_L2, 1'b1);
    check("wr_done_pmem_write", bus.pmem_write, 1'b0);
    check("wr_rdata_kept", bus.rdata_L2, exp_rdata);
    @(negedge clk);
    check("wr_after_resp", bus.resp_L2, 1'b0);
    check("wr_after_pmem_write", bus.pmem_write, 1'b0);
  endtask

  initial begin
    rst            = 1'b1;
    bus.read_L2    = 1'b0;
    bus.write_L2   = 1'b0;
    bus.addr_L2    = '0;
    bus.wdata_L2   = '0;
    bus.pmem_rdata = '0;
    bus.pmem_resp  = 1'b0;
    exp_rdata      = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_pmem_read", bus.pmem_read, 1'b0);
    check("rst_pmem_write", bus.pmem_write, 1'b0);
    check("rst_address", bus.pmem_address, 32'h0);
    check("rst_wdata", bus.pmem_wdata, '0);
    check("rst_resp", bus.resp_L2, 1'b0);
    check("rst_rdata", bus.rdata_L2, '0);
    rst = 1'b0;

    // Directed read with fixed beats, response every cycle
    beats[0] = {16{4'h1}};
    beats[1] = {16{4'h2}};
    beats[2] = {16{4'h3}};
    beats[3] = {16{4'h4}};
    do_read(32'h0000_1234, 1'b0, 0, 1'b0, 1'b0, -1);

    // Directed write, two idle cycles before each beat; rdata must be kept
    do_write(32'h0000_2000,
             {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}}, 2);

    // Read and write requested together: read only
    do_read(32'h0000_3040, 1'b1, -1, 1'b1, 1'b0, -1);

    // Stray pmem_resp in IDLE changes nothing; next read still assembles slot 0 first
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = rand_beat();
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    check("stray_pmem_read", bus.pmem_read, 1'b0);
    check("stray_pmem_write", bus.pmem_write, 1'b0);
    check("stray_resp", bus.resp_L2, 1'b0);
    do_read(32'h0000_4008, 1'b1, 1, 1'b0, 1'b0, -1);

    // Requests and pmem_resp during DONE are ignored
    do_read(32'h0000_5000, 1'b1, 0, 1'b0, 1'b1, -1);

    // Reset after beat 2 of a read, then read again at the first edge
    do_read(32'h0000_6000, 1'b1, 0, 1'b0, 1'b0, 2);
    rst = 1'b1;
    bus.pmem_resp = 1'b0;
    #1;
    check("midrst_pmem_read", bus.pmem_read, 1'b0);
    check("midrst_address", bus.pmem_address, 32'h0);
    check("midrst_resp", bus.resp_L2, 1'b0);
    check("midrst_rdata", bus.rdata_L2, '0);
    exp_rdata = '0;
    @(negedge clk);
    rst = 1'b0;
    do_read(32'h0000_7010, 1'b1, -1, 1'b0, 1'b0, -1);

    // Randomized mix of reads and writes
    for (int t = 0; t < 12; t++) begin
      if ($urandom_range(0, 1) == 0)
        do_read($urandom(), 1'b1, -1, 1'($urandom_range(0, 1)), 1'b0, -1);
      else
        do_write($urandom(), rand_line(), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/line_burst_adaptor.md
LINE_BURST_ADAPTOR -- requirements
Module: line_burst_adaptor

Interface
REQ-001 The block SHALL have parameter LINE_W, default 256, meaning cache line width in bits.
REQ-002 The block SHALL have parameter BEAT_W, default 64, meaning memory beat width in bits; NB = LINE_W/BEAT_W beats per line (integer, >=2).
REQ-003 The block SHALL have port clk, input, 1, the single clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset; one clock; reset is asynchronous and active-high.
REQ-005 The block SHALL have port read_L2, input, 1, line read request from the arbiter.
REQ-006 The block SHALL have port write_L2, input, 1, line write request from the arbiter.
REQ-007 The block SHALL have port addr_L2, input, 32, line address.
REQ-008 The block SHALL have port wdata_L2, input, LINE_W, line write data.
REQ-009 The block SHALL have port rdata_L2, output, LINE_W, assembled read line.
REQ-010 The block SHALL have port resp_L2, output, 1, one-cycle line-complete pulse.
REQ-011 The block SHALL have port pmem_read, output, 1, burst read request to memory.
REQ-012 The block SHALL have port pmem_write, output, 1, burst write request to memory.
REQ-013 The block SHALL have port pmem_address, output, 32, burst address.
REQ-014 The block SHALL have port pmem_wdata, output, BEAT_W, current write beat.
REQ-015 The block SHALL have port pmem_rdata, input, BEAT_W, current read beat.
REQ-016 The block SHALL have port pmem_resp, input, 1, beat accepted or valid, one per beat.

Function
REQ-017 The FSM SHALL have states IDLE, READ, WRITE, DONE.
REQ-018 In IDLE, on read_L2=1 the block SHALL latch addr_L2 and go to READ; otherwise on write_L2=1 latch addr_L2 and wdata_L2 and go to WRITE; read wins if both are set.
REQ-019 In READ, the block SHALL drive pmem_read=1 and pmem_address=latched address; each cycle with pmem_resp=1 it SHALL store pmem_rdata into beat slot cnt (slot 0 = bits [BEAT_W-1:0]) and increment cnt.
REQ-020 In WRITE, the block SHALL drive pmem_write=1 and pmem_wdata=latched line slice cnt; each cycle with pmem_resp=1 it SHALL increment cnt.
REQ-021 On the pmem_resp for beat NB-1, the block SHALL go to DONE and reset cnt to 0; pmem_read/pmem_write SHALL be 0 in DONE.
REQ-022 In DONE, the block SHALL assert resp_L2=1 for exactly one cycle, then go to IDLE.
REQ-023 rdata_L2 SHALL be registered, hold the last completed read line until the next read completes, and be unchanged by writes.
REQ-024 Read latency SHALL be: request sampled at edge 0, pmem_read high from cycle 1, beats accepted in the same cycle as the first pmem_resp, resp_L2 in the cycle after the last beat (minimum NB+2 cycles).
REQ-025 Request deassertion mid-burst SHALL be ignored; the burst SHALL complete.
REQ-026 pmem_resp in IDLE or DONE SHALL be ignored.
REQ-027 Requests present during DONE SHALL NOT be accepted until IDLE.
REQ-028 pmem_read and pmem_write SHALL never both be 1.

Reset
REQ-029 rst=1 SHALL immediately force state IDLE, cnt=0, the latched address, latched write line and rdata_L2 to 0, and all outputs to 0, including mid-burst.
REQ-030 After rst deasserts, the first request SHALL be accepted at the first rising edge.

Configuration
REQ-031 With LINE_ADDR_ALIGN_EN defined, pmem_address SHALL be the latched address with bits [log2(LINE_W/8)-1:0] forced to 0; without it, pmem_address SHALL be the latched address unmodified.

Verification
REQ-032 Read addr_L2=0x00001234, pmem_rdata beats 0x11..,0x22..,0x33..,0x44.., pmem_resp every cycle -> pmem_address=0x00001220 (aligned build), resp_L2 once, rdata_L2={0x44..,0x33..,0x22..,0x11..}.
REQ-033 Write wdata_L2=256'hDDDD..CCCC..BBBB..AAAA.., pmem_resp with two idle cycles between beats -> pmem_wdata=AAAA..,BBBB..,CCCC..,DDDD.. in order, each held until its pmem_resp; one resp_L2; rdata_L2 unchanged.
REQ-034 read_L2 and write_L2 both 1 in IDLE -> read burst only, pmem_write stays 0.
REQ-035 rst asserted after beat 2 of a read -> outputs 0 in the same cycle; a new read then returns all fresh beats with a single resp_L2.
REQ-036 read_L2 dropped after 1 cycle, stray pmem_resp in IDLE -> burst still completes NB beats; the stray pulse causes no state change.
